// File: rtl/qdma_request_arbiter.sv
// qdma_request_arbiter
//   Front-end for the QDMA transfer engine. Channels post 18-bit descriptors which are
//   accepted round-robin into a small FIFO. Descriptors are issued one at a time: the
//   fields are loaded, drq is raised until dack (or a timeout), then the block waits for
//   transfer_done. After every transfer, and after reset, the engine is re-armed by
//   holding dma_rst high for RST_CYCLES cycles.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ch_req / ch_desc    per-channel request and descriptor, held until ch_ack
//   ch_ack              one-hot pulse, descriptor written into the queue
//   ch_done / ch_err    one-hot pulse to the originating channel: completed / timed out
//   drq, dack           request handshake with the engine
//   transfer_done       completion level from the engine
//   dma_rst             synchronous active-high reset to the engine
//   transfer_type ..    descriptor fields to the engine, stable from LOAD through RECOVER
//   busy                high whenever the issue FSM is not idle
//   q_count             number of queued descriptors
module qdma_request_arbiter #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned Q_DEPTH    = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*18-1:0]     ch_desc,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic                     drq,
    input  logic                     dack,
    input  logic                     transfer_done,
    output logic                     dma_rst,
    output logic [1:0]               transfer_type,
    output logic [2:0]               src_module,
    output logic [2:0]               dest_module,
    output logic [4:0]               src_address,
    output logic [4:0]               dest_address,
    output logic                     busy,
    output logic [$clog2(Q_DEPTH):0] q_count
);

    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W   = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned DESC_W  = 18;
    localparam int unsigned ENT_W   = CH_W + DESC_W;
    localparam int unsigned TMR_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StReq, StBusy, StRecover} state_e;

    // ------------------------------------------------------------------
    // Descriptor queue and round-robin enqueue
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]  mem_q [Q_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              grant_found;
    logic [CH_W-1:0]   grant_id;
    logic [CH_W-1:0]   scan_idx;
    logic [DESC_W-1:0] grant_desc;
    logic              push;
    logic              pop;

    // Scan from the farthest channel to the nearest so the channel closest after the
    // pointer is the last one written and therefore wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = rr_q;
        scan_idx    = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            scan_idx = CH_W'((32'(rr_q) + 32'(i)) % NUM_CH);
            if (ch_req[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    assign grant_desc = ch_desc[32'(grant_id)*DESC_W +: DESC_W];

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    // Gated by rst_n so no channel sees an ack for a write the held-in-reset queue drops.
    assign push = rst_n && grant_found && (count_q < CNT_W'(Q_DEPTH));

    always_comb begin
        ch_ack = '0;
        if (push) begin
            ch_ack[grant_id] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CH_W-1:0]   id_q, id_d;
    logic [DESC_W-1:0] desc_q, desc_d;
    logic              drq_q, drq_d;
    logic              dma_rst_q, dma_rst_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [ENT_W-1:0]  head;

    assign head = mem_q[rd_ptr_q];
    assign pop  = (state_q == StIdle) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        rr_d     = push ? grant_id : rr_q;
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        id_d      = id_q;
        desc_d    = desc_q;
        drq_d     = drq_q;
        dma_rst_d = dma_rst_q;
        done_d    = '0;
        err_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    desc_d  = head[DESC_W-1:0];
                    id_d    = head[ENT_W-1 -: CH_W];
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Fields have been stable for a cycle before drq rises.
                drq_d   = 1'b1;
                tmr_d   = '0;
                state_d = StReq;
            end
            StReq: begin
                if (dack) begin
                    drq_d   = 1'b0;
                    state_d = StBusy;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    drq_d      = 1'b0;
                    err_d[id_q] = 1'b1;
                    dma_rst_d  = 1'b1;
                    tmr_d      = '0;
                    state_d    = StRecover;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            StBusy: begin
                if (transfer_done) begin
                    done_d[id_q] = 1'b1;
                    dma_rst_d    = 1'b1;
                    tmr_d        = '0;
                    state_d      = StRecover;
                end
            end
            StRecover: begin
                if (tmr_q == TMR_W'(RST_CYCLES - 1)) begin
                    dma_rst_d = 1'b0;
                    state_d   = StIdle;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset lands in RECOVER with dma_rst high so the engine always gets a full re-arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_q      <= CH_W'(NUM_CH - 1);
            state_q   <= StRecover;
            tmr_q     <= '0;
            id_q      <= '0;
            desc_q    <= '0;
            drq_q     <= 1'b0;
            dma_rst_q <= 1'b1;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_q      <= rr_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            id_q      <= id_d;
            desc_q    <= desc_d;
            drq_q     <= drq_d;
            dma_rst_q <= dma_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {grant_id, grant_desc};
        end
    end

    assign ch_done       = done_q;
    assign ch_err        = err_q;
    assign drq           = drq_q;
    assign dma_rst       = dma_rst_q;
    assign transfer_type = desc_q[17:16];
    assign src_module    = desc_q[15:13];
    assign dest_module   = desc_q[12:10];
    assign src_address   = desc_q[9:5];
    assign dest_address  = desc_q[4:0];
    assign busy          = (state_q != StIdle);
    assign q_count       = count_q;

endmodule

// File: tb/tb_qdma_request_arbiter.sv
// Randomised bench for qdma_request_arbiter. Channel drivers and an engine model create
// traffic; a transaction-level model predicts grants, queue occupancy, issue timing and
// completions. Expected issues and responses go into scoreboard queues that the monitor
// pops when the DUT raises drq or pulses ch_done / ch_err.
module tb_qdma_request_arbiter;

    localparam int NUM_CH     = 4;
    localparam int Q_DEPTH    = 4;
    localparam int TIMEOUT    = 64;
    localparam int RST_CYCLES = 2;
    localparam int CNT_W      = $clog2(Q_DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH*18-1:0] ch_desc;
    logic [NUM_CH-1:0]    ch_ack, ch_done, ch_err;
    logic                 drq, dack, transfer_done, dma_rst, busy;
    logic [1:0]           transfer_type;
    logic [2:0]           src_module, dest_module;
    logic [4:0]           src_address, dest_address;
    logic [CNT_W-1:0]     q_count;

    qdma_request_arbiter #(
        .NUM_CH(NUM_CH), .Q_DEPTH(Q_DEPTH), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_desc(ch_desc), .ch_ack(ch_ack),
        .ch_done(ch_done), .ch_err(ch_err), .drq(drq), .dack(dack),
        .transfer_done(transfer_done), .dma_rst(dma_rst), .transfer_type(transfer_type),
        .src_module(src_module), .dest_module(dest_module), .src_address(src_address),
        .dest_address(dest_address), .busy(busy), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; logic [17:0] desc;} ent_t;
    typedef struct {int ch; bit err; int due;} resp_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    ent_t        mq[$];
    ent_t        exp_issue[$];
    resp_t       exp_resp[$];
    int          first_acks[$];
    int          last_gnt, rec_start, pop_cyc, req_cnt, cyc, cur_ch;
    bit          active, in_req, in_busy, drq_prev, mon_on;
    logic [17:0] cur_desc;
    bit          saw_full, saw_tmo, saw_done, pressure;
    logic [NUM_CH-1:0] ack_seen;

    function automatic int exp_grant(input logic [NUM_CH-1:0] req, input int last);
        for (int k = 1; k <= NUM_CH; k++) begin
            if (req[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete(); exp_issue.delete(); exp_resp.delete();
        last_gnt = NUM_CH - 1; rec_start = 0; pop_cyc = 0; req_cnt = 0; cyc = 0; cur_ch = 0;
        active = 0; in_req = 0; in_busy = 0; drq_prev = 0; cur_desc = '0;
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] exp_ack, exp_done, exp_err;
        int g;
        bit in_rec;
        ent_t e;
        resp_t r;
        g = (mq.size() < Q_DEPTH) ? exp_grant(ch_req, last_gnt) : -1;
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        chk("ch_ack", ch_ack, exp_ack);
        chk("q_count", q_count, mq.size());
        if (mq.size() == Q_DEPTH) saw_full = 1;
        in_rec = (cyc >= rec_start) && (cyc < rec_start + RST_CYCLES);
        chk("dma_rst", dma_rst, in_rec);
        chk("drq", drq, in_req);
        chk("busy", busy, active || (cyc < rec_start + RST_CYCLES));
        chk("fields", {transfer_type, src_module, dest_module, src_address, dest_address},
            cur_desc);
        if (drq && !drq_prev) begin
            if (exp_issue.size() == 0) begin
                chk("unexpected_drq", drq, 1'b0);
            end else begin
                e = exp_issue.pop_front();
                chk("issue_desc",
                    {transfer_type, src_module, dest_module, src_address, dest_address},
                    e.desc);
            end
        end
        drq_prev = drq;
        exp_done = '0;
        exp_err  = '0;
        if (exp_resp.size() > 0 && exp_resp[0].due == cyc) begin
            r = exp_resp.pop_front();
            if (r.err) exp_err[r.ch] = 1'b1;
            else exp_done[r.ch] = 1'b1;
        end
        chk("ch_done", ch_done, exp_done);
        chk("ch_err", ch_err, exp_err);

        // Advance the model by one cycle
        if (in_req) begin
            if (dack) begin
                in_req = 0; in_busy = 1;
            end else if (req_cnt == TIMEOUT - 1) begin
                in_req = 0; active = 0; rec_start = cyc + 1; saw_tmo = 1;
                exp_resp.push_back('{ch: cur_ch, err: 1'b1, due: cyc + 1});
            end else begin
                req_cnt++;
            end
        end else if (in_busy) begin
            if (transfer_done) begin
                in_busy = 0; active = 0; rec_start = cyc + 1; saw_done = 1;
                exp_resp.push_back('{ch: cur_ch, err: 1'b0, due: cyc + 1});
            end
        end else if (active && cyc == pop_cyc + 1) begin
            in_req = 1; req_cnt = 0;
        end
        if (!active && cyc >= rec_start + RST_CYCLES && mq.size() > 0) begin
            e = mq.pop_front();
            cur_ch = e.ch; cur_desc = e.desc; active = 1; pop_cyc = cyc;
            exp_issue.push_back(e);
        end
        if (g >= 0) begin
            e.ch = g; e.desc = ch_desc[g*18 +: 18];
            mq.push_back(e);
            last_gnt = g;
            if (first_acks.size() < 4) first_acks.push_back(g);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            ack_seen = ch_ack;
            if (mon_on) begin
                model_step();
                cyc++;
            end
        end
    end

    // Channel drivers: hold request until acked, then idle for a random gap
    initial begin
        int gap[NUM_CH];
        for (int c = 0; c < NUM_CH; c++) gap[c] = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_req[c]) begin
                        if (ack_seen[c]) begin
                            ch_req[c] = 1'b0;
                            gap[c] = pressure ? $urandom_range(0, 2) : $urandom_range(0, 40);
                        end
                    end else if (gap[c] == 0) begin
                        ch_req[c] = 1'b1;
                        ch_desc[c*18 +: 18] = 18'($urandom);
                    end else begin
                        gap[c]--;
                    end
                end
            end
        end
    end

    // Engine model: dack after a random delay (sometimes never), then transfer_done
    // held until dma_rst; occasional stray dack / transfer_done while idle.
    initial begin
        int eng, cnt, wait_n;
        eng = 0; cnt = 0; wait_n = 0;
        forever begin
            @(posedge clk); #1;
            dack = 1'b0;
            if (!rst_n) begin
                transfer_done = 1'b0; eng = 0;
            end else begin
                if (eng == 0) begin
                    transfer_done = 1'b0;
                    if (drq) begin
                        eng = 1; cnt = 0;
                        wait_n = ($urandom_range(0, 4) == 0) ? 1000 : $urandom_range(0, 6);
                    end else if ($urandom_range(0, 19) == 0) begin
                        dack = 1'b1;
                    end else if ($urandom_range(0, 19) == 0) begin
                        transfer_done = 1'b1;
                    end
                end
                if (eng == 1) begin
                    if (!drq) eng = 0;
                    else if (cnt == wait_n) begin
                        dack = 1'b1; eng = 2; cnt = 0; wait_n = $urandom_range(0, 8);
                    end else cnt++;
                end else if (eng == 2) begin
                    if (cnt == wait_n) begin transfer_done = 1'b1; eng = 3; end
                    else cnt++;
                end else if (eng == 3) begin
                    if (dma_rst) begin transfer_done = 1'b0; eng = 0; end
                end
            end
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0; ch_req = '1; dack = 1'b0; transfer_done = 1'b0;
        mon_on = 0; pressure = 1; saw_full = 0; saw_tmo = 0; saw_done = 0; ack_seen = '0;
        for (int c = 0; c < NUM_CH; c++) ch_desc[c*18 +: 18] = 18'($urandom);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ch_ack", ch_ack, '0);
        chk("rst_dma_rst", dma_rst, 1'b1);
        chk("rst_drq", drq, 1'b0);
        chk("rst_q_count", q_count, '0);
        chk("rst_done_err", {ch_done, ch_err}, '0);
        chk("rst_fields", {transfer_type, src_module, dest_module, src_address, dest_address},
            '0);
        @(posedge clk); #1;
        rst_n = 1'b1; model_reset(); mon_on = 1;
        repeat (1500) @(posedge clk);
        pressure = 0;
        repeat (1500) @(posedge clk);
        pressure = 1;
        repeat (50) @(posedge clk);

        // Assert reset in the middle of a BUSY transfer
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk); #2;
            if (in_busy && !transfer_done) found = 1;
        end
        chk("busy_reached", found, 1'b1);
        rst_n = 1'b0; mon_on = 0;
        #1;
        chk("midrst_dma_rst", dma_rst, 1'b1);
        chk("midrst_drq", drq, 1'b0);
        chk("midrst_q_count", q_count, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", {ch_done, ch_err}, '0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; model_reset(); mon_on = 1;
        repeat (400) @(posedge clk);
        @(negedge clk); #1;
        mon_on = 0;

        chk("first_ack_count", first_acks.size(), 4);
        for (int i = 0; i < first_acks.size(); i++) chk("first_ack_order", first_acks[i], i);
        chk("saw_full_queue", saw_full, 1'b1);
        chk("saw_timeout", saw_tmo, 1'b1);
        chk("saw_done", saw_done, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
